// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder and its
// response buffer.
package imem_responder_pkg;

  localparam int ADDR_W          = 16;
  localparam int DEPTH_WORDS_DEF = 256;

  localparam logic [7:0] NOP_HIGH = 8'h00;
  localparam logic [7:0] NOP_LOW  = 8'h00;

  typedef struct packed {
    logic [7:0] high;
    logic [7:0] low;
  } instr_word_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        high;
    logic [7:0]        low;
    logic              fault;
  } rsp_rec_t;

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// Circular buffer of response records. Pointers wrap modulo QDEPTH, so any
// depth works, not only powers of two.
module rsp_fifo
  import imem_responder_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  rsp_rec_t push_rec,
  input  logic     pop,
  output rsp_rec_t head_rec,
  output logic     full,
  output logic     empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rsp_rec_t      buf_q [QDEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned; that is what keeps this block from inferring latches.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so all flops update from pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; validity lives in the pointers and count, and reset-free RAM maps onto memory primitives.
  always_ff @(posedge clk) begin
    if (push && !flush) buf_q[wr_ptr_q] <= push_rec;
  end

  assign head_rec = buf_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(QDEPTH));

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch requests, fixed-latency read
// pipe, credit-limited response buffer and a loader write port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [7:0]        instruction_code_high,
  output logic [7:0]        instruction_code_low,
  output logic              rsp_fault,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data_high,
  input  logic [7:0]        ld_data_low
);

  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  instr_word_t       mem [DEPTH_WORDS];
  logic [ADDR_W-2:0] req_widx, ld_widx;
  logic              req_fault, ld_in_range;
  logic              accept, pop, push_v;
  logic              fifo_full, fifo_empty;
  instr_word_t       rd_word;
  rsp_rec_t          acc_rec, push_rec, head_rec;
  logic [CW-1:0]     credit_q, credit_d;
  logic              unused_ld_lsb;

  assign unused_ld_lsb = ld_addr[0];
  assign req_widx      = req_addr[ADDR_W-1:1];
  assign ld_widx       = ld_addr[ADDR_W-1:1];
  assign req_fault     = req_addr[0] | (32'(req_widx) >= DEPTH_WORDS);
  assign ld_in_range   = (32'(ld_widx) < DEPTH_WORDS);

  // Combinational read plus edge write gives read-before-write on a collision.
  assign rd_word = mem[req_widx[MW-1:0]];

  always_ff @(posedge clk) begin
    if (ld_we && ld_in_range) mem[ld_widx[MW-1:0]] <= '{high: ld_data_high, low: ld_data_low};
  end

  assign req_ready = enable & ~flush & ~reset & (credit_q < CW'(QDEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = enable & ~flush & ~reset & ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    acc_rec.addr  = req_addr;
    acc_rec.fault = req_fault;
    acc_rec.high  = req_fault ? NOP_HIGH : rd_word.high;
    acc_rec.low   = req_fault ? NOP_LOW  : rd_word.low;
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_v   = accept;
      assign push_rec = acc_rec;
    end else begin : g_pipe
      logic [LATENCY-2:0] pipe_v_q, pipe_v_d;
      rsp_rec_t           pipe_rec_q [LATENCY-1];
      rsp_rec_t           pipe_rec_d [LATENCY-1];

      always_comb begin
        pipe_v_d   = pipe_v_q;
        pipe_rec_d = pipe_rec_q;
        if (enable) begin
          pipe_v_d[0]   = accept;
          pipe_rec_d[0] = acc_rec;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_rec_d[i] = pipe_rec_q[i-1];
          end
        end
        if (flush) pipe_v_d = '0;
      end

      always_ff @(posedge clk) begin
        if (reset) pipe_v_q <= '0;
        else       pipe_v_q <= pipe_v_d;
        pipe_rec_q <= pipe_rec_d;
      end

      assign push_v   = enable & pipe_v_q[LATENCY-2];
      assign push_rec = pipe_rec_q[LATENCY-2];
    end
  endgenerate

  // Credits count pipe plus buffer occupancy; a pop frees its slot next cycle.
  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + 1'b1;
    else if (!accept && pop) credit_d = credit_q - 1'b1;
    if (flush) credit_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

  rsp_fifo #(.QDEPTH(QDEPTH)) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push_v & ~fifo_full),
    .push_rec (push_rec),
    .pop      (pop),
    .head_rec (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    rsp_addr              = '0;
    instruction_code_high = NOP_HIGH;
    instruction_code_low  = NOP_LOW;
    rsp_fault             = 1'b0;
    if (rsp_valid) begin
      rsp_addr              = head_rec.addr;
      instruction_code_high = head_rec.high;
      instruction_code_low  = head_rec.low;
      rsp_fault             = head_rec.fault;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_imem_responder;

  localparam int LAT = 2;
  localparam int QD  = 2;
  localparam int DW  = 256;

  logic        clk = 1'b0;
  logic        reset, enable, flush;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, ld_we;
  logic [15:0] req_addr, rsp_addr, ld_addr;
  logic [7:0]  instruction_code_high, instruction_code_low, ld_data_high, ld_data_low;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] code;
    logic        fault;
    int          age;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [DW];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .flush                 (flush),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_addr              (req_addr),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_addr              (rsp_addr),
    .instruction_code_high (instruction_code_high),
    .instruction_code_low  (instruction_code_low),
    .rsp_fault             (rsp_fault),
    .ld_we                 (ld_we),
    .ld_addr               (ld_addr),
    .ld_data_high          (ld_data_high),
    .ld_data_low           (ld_data_low)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_we = 1'b1;
    ld_addr = a;
    {ld_data_high, ld_data_low} = d;
    tick();
    ld_we = 1'b0;
  endtask

  // Monitor: an entry is visible once it has seen LATENCY enabled edges
  // since acceptance; outstanding count is simply the scoreboard size.
  always @(negedge clk) begin : mon
    logic exp_ready, exp_valid, acc, pop;
    exp_t e;
    exp_ready = enable && !flush && !reset && (sb.size() < QD);
    exp_valid = enable && !flush && !reset && (sb.size() > 0) && (sb[0].age >= LAT);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (rsp_valid && exp_valid)
      check("rsp_payload",
            64'({rsp_addr, instruction_code_high, instruction_code_low, rsp_fault}),
            64'({sb[0].addr, sb[0].code, sb[0].fault}));
    acc = req_valid && exp_ready;
    pop = exp_valid && rsp_ready;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (enable) foreach (sb[i]) sb[i].age++;
      if (acc) begin
        e.addr  = req_addr;
        e.fault = req_addr[0] || (int'(req_addr[15:1]) >= DW);
        e.code  = e.fault ? 16'h0000 : ref_mem[req_addr[8:1]];
        e.age   = 1;
        sb.push_back(e);
      end
    end
    if (ld_we && int'(ld_addr[15:1]) < DW) ref_mem[ld_addr[8:1]] = {ld_data_high, ld_data_low};
  end

  task automatic check_reset_outputs();
    check("rst_rsp_addr", 64'(rsp_addr), 64'(0));
    check("rst_code_high", 64'(instruction_code_high), 64'(0));
    check("rst_code_low", 64'(instruction_code_low), 64'(0));
    check("rst_rsp_fault", 64'(rsp_fault), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data_high = '0; ld_data_low = '0;
    repeat (2) tick();
    @(negedge clk);
    check_reset_outputs();
    #1 reset = 1'b0;
    tick();

    for (int i = 0; i < DW; i++) load(16'(i * 2), 16'($urandom));
    load(16'h0000, 16'h1234);
    load(16'h0002, 16'hABCD);

    // Back-to-back requests with the consumer always ready.
    req_valid = 1'b1; req_addr = 16'h0000; tick();
    req_addr = 16'h0002; tick();
    req_valid = 1'b0; repeat (4) tick();

    // Backpressure: credits run out after QDEPTH accepts.
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr = 16'($urandom_range(0, DW - 1) * 2);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1; repeat (4) tick();

    // Misaligned and out-of-range requests.
    req_valid = 1'b1; req_addr = 16'h0003; tick();
    req_addr = 16'h0200; tick();
    req_valid = 1'b0; repeat (4) tick();

    // Loader write colliding with a read of the same word.
    req_valid = 1'b1; req_addr = 16'h0002;
    ld_we = 1'b1; ld_addr = 16'h0002; {ld_data_high, ld_data_low} = 16'h5555;
    tick();
    ld_we = 1'b0; tick();
    req_valid = 1'b0; repeat (4) tick();

    // Flush with two requests in flight, then a fresh request.
    req_valid = 1'b1; req_addr = 16'h0000; tick();
    req_addr = 16'h0002; tick();
    req_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; req_valid = 1'b1; req_addr = 16'h0000; tick();
    req_valid = 1'b0; repeat (4) tick();

    // Freeze with one response buffered, then release.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'h0000; tick();
    req_valid = 1'b0; repeat (3) tick();
    enable = 1'b0; repeat (3) tick();
    enable = 1'b1; tick();
    rsp_ready = 1'b1; repeat (2) tick();

    // Reset in the middle of a stream.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'h0002; repeat (3) tick();
    req_valid = 1'b0; reset = 1'b1; tick();
    @(negedge clk);
    check_reset_outputs();
    #1 reset = 1'b0; rsp_ready = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      req_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r == 0)      req_addr = 16'($urandom);
      else if (r == 1) req_addr = 16'($urandom_range(0, 511)) | 16'h0001;
      else             req_addr = 16'($urandom_range(0, DW - 1) * 2);
      rsp_ready = ($urandom_range(0, 3) != 0);
      ld_we     = ($urandom_range(0, 7) == 0);
      ld_addr   = 16'($urandom_range(0, 511));
      {ld_data_high, ld_data_low} = 16'($urandom);
      tick();
    end

    // Drain whatever is still outstanding, with a bounded wait.
    reset = 1'b0; flush = 1'b0; enable = 1'b1; req_valid = 1'b0;
    ld_we = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    check("drain_empty", 64'(sb.size()), 64'(0));
    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder that serves the fetch side's program-counter requests and returns each 16-bit instruction as a high byte and a low byte.
- Adds a valid/ready request channel, a fixed-latency read pipeline, and a credit-limited response buffer, so the fetch stage can pipeline requests and apply backpressure.
- Includes a loader write port for program initialisation.
- Sits between the fetch PC register and the decode input.

Parameters:
- ADDR_W, 16, byte-address width of the fetch request.
- DEPTH_WORDS, 256, number of 16-bit instruction words stored.
- LATENCY, 2, cycles from request accept to the response entering the output buffer (must be at least 1).
- QDEPTH, 2, maximum outstanding requests (in pipeline plus in buffer); also the output buffer depth.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global run; 0 freezes all state.
- flush  in  1  discards all outstanding requests and responses.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both 1.
- req_addr  in  ADDR_W  byte address of the instruction.
- rsp_valid  out  1  response at buffer head.
- rsp_ready  in  1  consumer pops the head when rsp_valid and rsp_ready are both 1.
- rsp_addr  out  ADDR_W  echo of the request address.
- instruction_code_high  out  8  instruction bits [15:8].
- instruction_code_low  out  8  instruction bits [7:0].
- rsp_fault  out  1  request was misaligned or out of range.
- ld_we  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader byte address; bit 0 is ignored.
- ld_data_high  in  8  loader high byte.
- ld_data_low  in  8  loader low byte.

Behaviour:
- Reset (synchronous, active-high):
  - Clears the pipeline valids, buffer pointers and credit count.
  - Outputs after reset: req_ready=1 (if enable=1), rsp_valid=0, rsp_addr=0, both code bytes 0x00, rsp_fault=0.
  - Memory contents are not cleared.
- Word index: req_addr[ADDR_W-1:1]. Fault if req_addr[0]=1 or word index >= DEPTH_WORDS. A fault response carries code bytes 0x00/0x00 and rsp_fault=1.
- Memory read happens in the accept cycle. Same-cycle ld_we to the same word is read-before-write: the response carries the old data.
- Latency: a request accepted at cycle t has its response at the buffer head visible at t+LATENCY at the earliest.
- Ordering is strictly in request order.
- Credits:
  - outstanding = entries in the pipeline + entries in the buffer.
  - req_ready = enable and not flush and (outstanding < QDEPTH).
  - A pop in the same cycle does not free a credit until the next cycle.
  - No overflow is possible, and the buffer never drops a response.
- Accept and pop in the same cycle: outstanding is unchanged.
- Buffer: circular, QDEPTH entries, pointers wrap modulo QDEPTH.
  - Full means QDEPTH entries stored.
  - Empty drives rsp_valid=0.
- Response hold: rsp_valid, once asserted, holds its payload stable until popped (or until flush, reset, or enable=0).
- enable=0:
  - Pipeline, buffer and credits hold.
  - req_ready=0 and rsp_valid=0. No accept and no pop occur.
  - Loader writes still occur.
- flush=1, at the next edge:
  - All pipeline valids and the buffer are cleared and outstanding returns to 0.
  - req_ready=0 during the flush cycle.
  - rsp_valid=0 from the cycle after flush.
  - Flush overrides enable=0.
- Reset asserted mid-operation behaves identically to flush, plus resetting outputs to their reset values.
- No state machine beyond the credit counter, the LATENCY-deep valid/data shift pipe, and the buffer pointers.

Decomposition:
- Shared package holds:
  - ADDR_W and the default DEPTH_WORDS.
  - The instruction word typedef (16 bits, split into high and low bytes).
  - The response record (addr, high, low, fault).
  - NOP_HIGH/NOP_LOW = 0x00.
- One natural sub-module, rsp_fifo: parameterised QDEPTH circular buffer of response records with push/pop, full/empty and a flush input.
- The memory array, read pipe and credit logic stay in the top module.

Test Plan:
- Load words 0x1234 at addr 0x0000 and 0xABCD at 0x0002. Request 0x0000 then 0x0002 back-to-back with rsp_ready=1 -> responses at t+2 and t+3 with bytes 12/34 then AB/CD, rsp_fault=0, in order.
- Hold rsp_ready=0 and drive requests every cycle -> req_ready drops after 2 accepts. Raise rsp_ready -> two responses drain in order and req_ready returns 1 the cycle after the first pop.
- Request addr 0x0003, then 0x0200 with DEPTH_WORDS=256 -> both responses have rsp_fault=1 and bytes 00/00; rsp_addr echoes 0x0003 and 0x0200.
- Same-cycle ld_we to word 1 with 0x5555 while requesting 0x0002 (old value 0xABCD) -> response AB/CD. A following request to 0x0002 -> 55/55.
- Two requests in flight plus flush=1 -> rsp_valid never rises for them, outstanding returns to 0, and a new request to 0x0000 returns 12/34 after 2 cycles.
- Drop enable=0 for 3 cycles with one response buffered -> rsp_valid=0 and req_ready=0 throughout. When enable returns to 1, the same response reappears unchanged. Assert reset mid-stream -> all outputs return to their reset values on the next edge.
